// File: rtl/fibonacci_index.sv
// Inverse Fibonacci: iteratively finds the largest n with F(n) <= din and
// flags whether din is itself a Fibonacci number. Uses a start/done handshake.
module fibonacci_index #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         start,
  output logic [W-1:0] dout,
  output logic         done,
  output logic         exact,
  output logic         busy
);

  // Handshake: start is accepted on a rising edge only in IDLE or DONE.
  // busy is high while the search runs; done and the dout/exact pair stay
  // valid from completion until the next accepted start. busy and done are
  // never high together.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] din_q, din_d;
  logic [W:0]   a_q, a_d;
  logic [W:0]   b_q, b_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] dout_q, dout_d;
  logic         exact_q, exact_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  // The extra MSB on a/b keeps F(n+1) from wrapping once it passes 2^W-1.
  logic [W:0] din_ext;
  assign din_ext = {1'b0, din_q};

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    dout_d  = dout_q;
    exact_d = exact_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          din_d   = din;
          a_d     = '0;
          b_d     = {{W{1'b0}}, 1'b1};
          n_d     = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (b_q <= din_ext) begin
          a_d = b_q;
          b_d = a_q + b_q;
          n_d = n_q + 1'b1;
        end else begin
          dout_d  = n_q;
          exact_d = (a_q == din_ext);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      din_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      dout_q  <= '0;
      exact_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      dout_q  <= dout_d;
      exact_q <= exact_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign dout  = dout_q;
  assign exact = exact_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fibonacci_index.sv
// Bench for fibonacci_index: vector table, hand sequences for reset/ignored
// start/held start, Fibonacci round trip, and random values against a model.
module tb_fibonacci_index;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         done, exact, busy;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];
  longint fib[0:25];

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] e_dout;
    logic         e_exact;
    int           e_lat;
  } vec_t;

  fibonacci_index #(.W(W)) dut (
    .clk(clk), .reset(reset), .din(din), .start(start),
    .dout(dout), .done(done), .exact(exact), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the Fibonacci table until the next term exceeds v.
  task automatic model(input logic [W-1:0] v, output int n, output logic ex);
    n = 0;
    while (fib[n+1] <= longint'(v)) n++;
    ex = (fib[n] == longint'(v));
  endtask

  task automatic launch(input logic [W-1:0] v);
    @(negedge clk);
    din   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    logic [W:0] e;
    int both;
    lat  = 0;
    both = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done && busy) both++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy/done excl"}, both, 0);
    e = exp_q.pop_front();
    check({tag, " dout"}, dout, e[W:1]);
    check({tag, " exact"}, exact, e[0]);
  endtask

  task automatic run(input logic [W-1:0] v, input logic [W-1:0] e_dout,
                     input logic e_exact, input string tag, output int lat);
    exp_q.push_back({e_dout, e_exact});
    launch(v);
    check({tag, " busy after accept"}, busy, 1);
    check({tag, " done low after accept"}, done, 0);
    wait_done(tag, lat);
  endtask

  initial begin
    vec_t vecs[8];
    int   lat, n;
    logic ex;
    logic [W-1:0] v;

    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i <= 25; i++) fib[i] = fib[i-1] + fib[i-2];

    vecs[0] = '{16'd0,     16'd0,  1'b1, 1};
    vecs[1] = '{16'd1,     16'd2,  1'b1, 3};
    vecs[2] = '{16'd5,     16'd5,  1'b1, 6};
    vecs[3] = '{16'd46368, 16'd24, 1'b1, 25};
    vecs[4] = '{16'd65535, 16'd24, 1'b0, 25};
    vecs[5] = '{16'd100,   16'd11, 1'b0, 12};
    vecs[6] = '{16'd2,     16'd3,  1'b1, 4};
    vecs[7] = '{16'd4,     16'd4,  1'b0, 5};

    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    #1;
    check("reset dout", dout, 0);
    check("reset done", done, 0);
    check("reset exact", exact, 0);
    check("reset busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // din=5: six busy cycles, then done held with start low
    run(16'd5, 16'd5, 1'b1, "seq5", lat);
    check("seq5 latency", lat, 6);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check("seq5 done held", done, 1);
    check("seq5 dout held", dout, 5);

    foreach (vecs[i]) begin
      run(vecs[i].din, vecs[i].e_dout, vecs[i].e_exact, $sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].e_lat);
    end

    // start while busy must be ignored
    exp_q.push_back({16'd11, 1'b0});
    launch(16'd100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    din   = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored start", lat);

    // asynchronous reset mid-run
    launch(16'd65535);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst dout", dout, 0);
    check("midrst done", done, 0);
    check("midrst exact", exact, 0);
    check("midrst busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    run(16'd3, 16'd4, 1'b1, "after reset", lat);
    check("after reset latency", lat, 5);

    // held start relaunches from DONE
    exp_q.push_back({16'd5, 1'b1});
    launch(16'd5);
    start = 1'b1;
    wait_done("held first", lat);
    @(posedge clk);
    #1;
    check("held relaunch done", done, 0);
    check("held relaunch busy", busy, 1);
    start = 1'b0;
    exp_q.push_back({16'd5, 1'b1});
    wait_done("held second", lat);

    // round trip of F(i) for i = 0..24
    for (int i = 0; i <= 24; i++) begin
      v = W'(fib[i]);
      run(v, (i == 1) ? 16'd2 : W'(i), 1'b1, $sformatf("rt%0d", i), lat);
    end

    // random values, with some near Fibonacci terms
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) v = W'(fib[$urandom_range(24, 0)] + longint'($urandom_range(1, 0)));
      else            v = W'($urandom_range(65535, 0));
      model(v, n, ex);
      run(v, W'(n), ex, $sformatf("rnd%0d din=%0d", k, v), lat);
      check($sformatf("rnd%0d latency", k), lat, n + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fibonacci_index.md
# fibonacci_index

Inverse of the `fibonacci` block: given a 16-bit value, it iteratively finds the largest index n with F(n) <= value. It also flags whether the value is itself a Fibonacci number. It shares the `fibonacci` start/done handshake, so the same bench driver and test harness run both blocks. Round-trip checks place it after `fibonacci`, feeding `fibonacci.dout` into `fibonacci_index.din`.

## Interface
- `W`, default 16: width of `din`/`dout`.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-high reset.
- `din`  input  W: value to invert; sampled only on the edge where `start` is accepted.
- `start`  input  1: request. Accepted only when not busy.
- `dout`  output  W: result index n, zero-extended. Valid while `done`=1.
- `done`  output  1: result valid. Held high until the next accepted `start`.
- `exact`  output  1: F(dout) == captured din. Valid while `done`=1.
- `busy`  output  1: computation in progress.

## Operation
- Sequence convention: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2), so F(5)=5 and F(24)=46368. F(25)=75025 exceeds 16 bits.
- Result: the largest n with F(n) <= din. For din=1 the result is 2 (F(2)=1), not 1.
- Internal registers:
  - `din_r` (W bits).
  - `a` and `b` (W+1 bits each), where `b` can reach F(25).
  - index counter `n` (W bits).
- States: IDLE, RUN, DONE.
- IDLE or DONE, `start`=1 on an edge:
  - `din_r`<=din, a<=0, b<=1, n<=0.
  - `done`<=0, `busy`<=1, go to RUN.
- RUN, each edge:
  - If b <= din_r: a<=b, b<=a+b, n<=n+1. Stay in RUN.
  - Else: `dout`<=n, `exact`<=(a==din_r), `done`<=1, `busy`<=0. Go to DONE.
- `start` in RUN is ignored. It is neither queued nor restarted, and `din` changes are ignored.
- DONE with no `start`: hold `dout`, `exact`, `done`.
- `a+b` must not wrap. Comparisons use the W+1-bit values. For W=16 the maximum result is 24 and the maximum `b` is 75025.
- Reset, asynchronous, at any time including mid-RUN:
  - State goes to IDLE.
  - `dout`=0, `done`=0, `exact`=0, `busy`=0; internal registers cleared.
  - A computation in progress is lost, and no `done` is produced for it.
- After reset deasserts, the first `start` is accepted on the next rising edge.

## Timing
- Edge k accepts `start` and sets `busy`=1 after edge k.
- RUN occupies edges k+1 through k+n+1. `done`=1 and `dout`=n become visible after edge k+n+1.
- Latency from the accepting edge is n+1 cycles. Worst case for W=16 is 25 cycles.
  - din=0: `done` after edge k+1.
  - din=5: `done` after edge k+6.
- `done` and `busy` are never both 1.
- When a new `start` is accepted in DONE, `done` falls after the same edge.
- `start` is level-sampled. Holding it high in DONE re-launches the computation on every DONE edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset pulse, then din=5 with a 1-cycle `start`:
  - `busy` for 6 cycles, then `done`=1, `dout`=5, `exact`=1.
  - `done` stays high 10+ cycles with `start` low.
- Boundary values, one run each:
  - din=0 → `dout`=0, `exact`=1, latency 1.
  - din=1 → `dout`=2, `exact`=1.
  - din=46368 → `dout`=24, `exact`=1.
  - din=65535 → `dout`=24, `exact`=0, latency 25.
- din=100 → `dout`=11, `exact`=0 (F(11)=89, F(12)=144).
  - While busy, pulse `start` with din=5. The result must remain 11.
- din=65535, assert `reset` asynchronously mid-cycle 10 cycles after `start`:
  - All outputs go 0 immediately.
  - A subsequent din=3 run returns `dout`=4, `exact`=1.
- Round trip: chain `fibonacci` outputs for inputs 0..24 into this block. Each `dout` must equal the original index, with `exact`=1, except input 1, which must return 2.
